match_controller: RTL and testbench

//  Match-level FSM downstream of the point/score generator. Consumes points_1/points_2,

---
 rtl/match_controller.sv | 182 ++++++++++++++++++
 tb/tb_match_controller.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/match_controller.sv
// Match-level controller: idle -> countdown -> timed round -> game over.
// Watches the two player scores, keeps the round clock and declares the winner.
// All outputs come straight from registers; every decision lands one cycle after
// the condition that caused it.
module match_controller #(
  parameter int TICKS_PER_SEC     = 65_000_000,
  parameter int MATCH_SECONDS     = 90,
  parameter int COUNTDOWN_SECONDS = 3,
  parameter int WIN_SCORE         = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] points_1,
  input  logic [4:0] points_2,
  output logic [1:0] state,
  output logic [1:0] winner,
  output logic [6:0] seconds_left,
  output logic [1:0] countdown,
  output logic       game_rst,
  output logic       move_en,
  output logic       sec_tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_SEC - 1);
  localparam logic [6:0]    SECS_INIT  = 7'(MATCH_SECONDS);
  localparam logic [1:0]    CD_INIT    = 2'(COUNTDOWN_SECONDS);
  localparam logic [4:0]    WIN_PTS    = 5'(WIN_SCORE);

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_DRAW = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_COUNTDOWN = 2'd1,
    ST_PLAYING   = 2'd2,
    ST_GAME_OVER = 2'd3
  } state_t;

  // Registered state and outputs
  state_t        r_state;
  logic [1:0]    r_winner;
  logic [6:0]    r_secs;
  logic [1:0]    r_cd;
  logic          r_game_rst;
  logic          r_move_en;
  logic          r_sec_tick;
  logic [PW-1:0] r_presc;
  logic          r_start_d;

  // Next-state values
  state_t        w_state_nxt;
  logic [1:0]    w_winner_nxt;
  logic [6:0]    w_secs_nxt;
  logic [1:0]    w_cd_nxt;
  logic          w_tick_nxt;
  logic [PW-1:0] w_presc_nxt;

  logic w_start_edge;
  logic w_wrap;
  logic w_p1_hit;
  logic w_p2_hit;

  assign w_start_edge = start & ~r_start_d;
  assign w_wrap       = ((r_state == ST_COUNTDOWN) || (r_state == ST_PLAYING)) &&
                        (r_presc == PRESC_LAST);
  assign w_p1_hit     = (points_1 >= WIN_PTS);
  assign w_p2_hit     = (points_2 >= WIN_PTS);

  // State register plus every registered output, with synchronous reset
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the values seen before the edge.
    if (rst) begin
      r_state    <= ST_IDLE;
      r_winner   <= WIN_NONE;
      r_secs     <= SECS_INIT;
      r_cd       <= 2'd0;
      r_game_rst <= 1'b1;
      r_move_en  <= 1'b0;
      r_sec_tick <= 1'b0;
      r_presc    <= '0;
      r_start_d  <= 1'b1;   // a button held through reset is not a press
    end else begin
      r_state    <= w_state_nxt;
      r_winner   <= w_winner_nxt;
      r_secs     <= w_secs_nxt;
      r_cd       <= w_cd_nxt;
      r_game_rst <= (w_state_nxt == ST_IDLE) || (w_state_nxt == ST_COUNTDOWN);
      r_move_en  <= (w_state_nxt == ST_PLAYING);
      r_sec_tick <= w_tick_nxt;
      r_presc    <= w_presc_nxt;
      r_start_d  <= start;
    end
  end

  // Next-state logic: prescaler, countdown, round clock and winner decision
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one
    // unassigned, which would otherwise infer a latch.
    w_state_nxt  = r_state;
    w_winner_nxt = r_winner;
    w_secs_nxt   = r_secs;
    w_cd_nxt     = r_cd;
    w_tick_nxt   = 1'b0;
    w_presc_nxt  = r_presc;

    unique case (r_state)
      ST_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt = ST_COUNTDOWN;
          w_cd_nxt    = CD_INIT;
        end
      end

      ST_COUNTDOWN: begin
        w_presc_nxt = w_wrap ? '0 : r_presc + 1'b1;
        if (w_wrap) begin
          w_tick_nxt = 1'b1;
          if (r_cd == 2'd1) begin
            w_state_nxt = ST_PLAYING;
            w_cd_nxt    = 2'd0;
            w_secs_nxt  = SECS_INIT;
          end else begin
            w_cd_nxt = r_cd - 2'd1;
          end
        end
      end

      ST_PLAYING: begin
        w_presc_nxt = w_wrap ? '0 : r_presc + 1'b1;
        if (w_wrap) begin
          w_tick_nxt = 1'b1;
          w_secs_nxt = (r_secs != 7'd0) ? r_secs - 7'd1 : 7'd0;
        end
        // Score limits outrank the clock, even on the final tick
        if (w_p1_hit && w_p2_hit) begin
          w_state_nxt  = ST_GAME_OVER;
          w_winner_nxt = WIN_DRAW;
        end else if (w_p1_hit) begin
          w_state_nxt  = ST_GAME_OVER;
          w_winner_nxt = WIN_P1;
        end else if (w_p2_hit) begin
          w_state_nxt  = ST_GAME_OVER;
          w_winner_nxt = WIN_P2;
        end else if (w_wrap && (r_secs == 7'd1)) begin
          w_state_nxt = ST_GAME_OVER;
          if (points_1 > points_2)      w_winner_nxt = WIN_P1;
          else if (points_2 > points_1) w_winner_nxt = WIN_P2;
          else                          w_winner_nxt = WIN_DRAW;
        end
      end

      ST_GAME_OVER: begin
        if (w_start_edge) begin
          w_state_nxt  = ST_COUNTDOWN;
          w_winner_nxt = WIN_NONE;
          w_secs_nxt   = SECS_INIT;
          w_cd_nxt     = CD_INIT;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    // Each state is entered with a fresh second
    if (w_state_nxt != r_state) w_presc_nxt = '0;
  end

  assign state        = r_state;
  assign winner       = r_winner;
  assign seconds_left = r_secs;
  assign countdown    = r_cd;
  assign game_rst     = r_game_rst;
  assign move_en      = r_move_en;
  assign sec_tick     = r_sec_tick;

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with a 4-cycle second, 5 s round,
// 3 s countdown and a winning score of 10. Inputs change and outputs are
// sampled on the falling clock edge.
module tb_match_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] points_1;
  logic [4:0] points_2;
  logic [1:0] state;
  logic [1:0] winner;
  logic [6:0] seconds_left;
  logic [1:0] countdown;
  logic       game_rst;
  logic       move_en;
  logic       sec_tick;

  int total = 0;
  int bad   = 0;

  match_controller #(
    .TICKS_PER_SEC    (4),
    .MATCH_SECONDS    (5),
    .COUNTDOWN_SECONDS(3),
    .WIN_SCORE        (10)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .points_1    (points_1),
    .points_2    (points_2),
    .state       (state),
    .winner      (winner),
    .seconds_left(seconds_left),
    .countdown   (countdown),
    .game_rst    (game_rst),
    .move_en     (move_en),
    .sec_tick    (sec_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total++;
    assert (observed === expected) else begin
      bad++;
      $display("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      $error("%s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle start press; returns on the first sample after the press lands
  task automatic press_start();
    start = 1'b1;
    wait_n(1);
    start = 1'b0;
  endtask

  initial begin
    rst = 1'b1; start = 1'b1; points_1 = 5'd4; points_2 = 5'd2;
    wait_n(3);
    rst = 1'b0;
    wait_n(2);
    // Button held through reset does not start a match
    check("rst_state",    state,        0);
    check("rst_game_rst", game_rst,     1);
    check("rst_move_en",  move_en,      0);
    check("rst_secs",     seconds_left, 5);
    check("rst_winner",   winner,       0);
    check("rst_cd",       countdown,    0);
    check("rst_tick",     sec_tick,     0);

    start = 1'b0;
    wait_n(1);
    check("held_idle", state, 0);
    press_start();
    check("cd_state", state,     1);
    check("cd_3",     countdown, 3);
    check("cd_grst",  game_rst,  1);

    wait_n(3);
    check("cd_still3", countdown, 3);
    check("cd_notick", sec_tick,  0);
    wait_n(1);
    check("cd_2",    countdown, 2);
    check("cd_tick", sec_tick,  1);
    // Start pressed mid-countdown is ignored
    press_start();
    wait_n(3);
    check("cd_1",      countdown, 1);
    check("cd_ignore", state,     1);
    wait_n(4);
    check("play_state", state,        2);
    check("play_move",  move_en,      1);
    check("play_grst",  game_rst,     0);
    check("play_secs",  seconds_left, 5);
    check("play_cd",    countdown,    0);

    // Start pressed mid-round is ignored; round times out at 4:2
    press_start();
    wait_n(3);
    for (int k = 4; k >= 1; k--) begin
      check("secs_step", seconds_left, k);
      check("secs_state", state, 2);
      wait_n(4);
    end
    check("to_state",  state,        3);
    check("to_winner", winner,       1);
    check("to_secs",   seconds_left, 0);
    check("to_move",   move_en,      0);
    check("to_grst",   game_rst,     0);

    // Rematch, timeout with a draw
    points_1 = 5'd3; points_2 = 5'd3;
    press_start();
    check("rm_state",  state,        1);
    check("rm_winner", winner,       0);
    check("rm_grst",   game_rst,     1);
    check("rm_secs",   seconds_left, 5);
    check("rm_cd",     countdown,    3);
    wait_n(12);
    check("rm_play", state, 2);
    wait_n(20);
    check("draw_state",  state,  3);
    check("draw_winner", winner, 3);

    // Player 2 reaches 10 mid-round
    points_1 = 5'd0; points_2 = 5'd9;
    press_start();
    wait_n(17);
    check("p2_pre_secs",  seconds_left, 4);
    check("p2_pre_state", state,        2);
    points_2 = 5'd10;
    wait_n(1);
    check("p2_state",  state,        3);
    check("p2_winner", winner,       2);
    check("p2_secs",   seconds_left, 4);
    wait_n(4);
    check("p2_frozen", seconds_left, 4);

    // Both players reach 10 in the same cycle
    points_1 = 5'd0; points_2 = 5'd0;
    press_start();
    wait_n(13);
    check("both_pre", state, 2);
    points_1 = 5'd10; points_2 = 5'd10;
    wait_n(1);
    check("both_state",  state,  3);
    check("both_winner", winner, 3);

    // Score hit on the final tick: score rule beats the time comparison
    points_1 = 5'd5; points_2 = 5'd9;
    press_start();
    wait_n(31);
    check("ft_pre_secs", seconds_left, 1);
    points_1 = 5'd10;
    wait_n(1);
    check("ft_state",  state,        3);
    check("ft_winner", winner,       1);
    check("ft_secs",   seconds_left, 0);

    // Reset mid-round
    points_1 = 5'd1; points_2 = 5'd2;
    press_start();
    wait_n(18);
    check("mr_pre", state, 2);
    rst = 1'b1;
    wait_n(1);
    rst = 1'b0;
    check("mr_state",  state,        0);
    check("mr_secs",   seconds_left, 5);
    check("mr_move",   move_en,      0);
    check("mr_grst",   game_rst,     1);
    check("mr_winner", winner,       0);
    wait_n(2);
    check("mr_idle", state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
